// File: rtl/wb_bridge_pkg.sv
// Shared state encodings and sizing helper for the Wishbone master bridge.
package wb_bridge_pkg;

    localparam logic [1:0] WB_IDLE           = 2'd0;
    localparam logic [1:0] WB_BUSY           = 2'd1;
    localparam logic [1:0] WB_RETRY_GAP      = 2'd2;
    localparam logic [1:0] WB_WAIT_FOR_STALL = 2'd3;

    // Counter width for values 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/wb_master_bridge_if.sv
// Wishbone B3 classic-cycle signal bundle between the bridge and the interconnect.
interface wb_master_bridge_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_we_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_stb_o;
    logic            wb_cyc_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_watchdog.sv
// Counts unterminated BUSY cycles and flags the last one allowed before a forced error.
module wb_watchdog
    import wb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);
    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_ok;
            assign unused_ok = ^{clk, rst, clear, count_en};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam int TW = clog2_min1(TIMEOUT + 1);

            logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

            assign expire = count_en && (tmo_cnt_q == TW'(TIMEOUT - 1));

            // Saturates at TIMEOUT-1; the bridge leaves BUSY on that cycle anyway.
            always_comb begin
                tmo_cnt_d = tmo_cnt_q;
                if (clear) begin
                    tmo_cnt_d = '0;
                end else if (count_en && !expire) begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    tmo_cnt_q <= '0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_d;
                end
            end
        end
    endgenerate
endmodule

// File: rtl/wb_master_bridge.sv
// CPU-to-Wishbone B3 classic-cycle master: one access at a time, bounded RTY
// re-issue, watchdog-to-error conversion, result held across pipeline stalls.
module wb_master_bridge
    import wb_bridge_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int STALLW    = 6,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALLW-1:0]  stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [AW-1:0]      cpu_addr_i,
    input  logic [DW-1:0]      cpu_data_i,
    input  logic [DW/8-1:0]    cpu_sel_i,
    output logic [DW-1:0]      cpu_data_o,
    output logic               cpu_err_o,
    output logic               stallreq_o,
    wb_master_bridge_if.master wb
);
    // state             | meaning
    // WB_IDLE           | no access; accepts a CPU request
    // WB_BUSY           | cyc/stb driven, waiting for ack/err/rty or watchdog
    // WB_RETRY_GAP      | one bus-idle cycle before re-issuing after RTY
    // WB_WAIT_FOR_STALL | access done, result presented until stall_i clears

    localparam int RW = clog2_min1(MAX_RETRY + 1);

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            we_q, we_d;
    logic [DW/8-1:0] sel_q, sel_d;
    logic            stb_q, stb_d;
    logic            cyc_q, cyc_d;
    logic [DW-1:0]   rd_buf_q, rd_buf_d;
    logic            err_buf_q, err_buf_d;
    logic [RW-1:0]   retry_cnt_q, retry_cnt_d;

    logic            live, t_ack, t_err, t_rty, quiet, retry_left;
    logic            wd_clear, wd_expire, bus_clear;
    logic [DW-1:0]   cpu_data;
    logic            cpu_err, stallreq;

    // Terminations only count while a cycle is actually on the bus.
    assign live       = (state_q == WB_BUSY) && cyc_q && stb_q;
    assign t_ack      = live && wb.wb_ack_i;
    assign t_err      = live && wb.wb_err_i;
    assign t_rty      = live && wb.wb_rty_i;
    assign quiet      = live && !wb.wb_ack_i && !wb.wb_err_i && !wb.wb_rty_i;
    assign retry_left = (retry_cnt_q != RW'(MAX_RETRY));

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear),
        .count_en (quiet),
        .expire   (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        sel_d       = sel_q;
        stb_d       = stb_q;
        cyc_d       = cyc_q;
        rd_buf_d    = rd_buf_q;
        err_buf_d   = err_buf_q;
        retry_cnt_d = retry_cnt_q;
        wd_clear    = 1'b0;
        bus_clear   = 1'b0;
        cpu_data    = '0;
        cpu_err     = 1'b0;
        stallreq    = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    adr_d       = cpu_addr_i;
                    dat_d       = cpu_data_i;
                    we_d        = cpu_we_i;
                    sel_d       = cpu_sel_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    retry_cnt_d = '0;
                    wd_clear    = 1'b1;
                    stallreq    = 1'b1;
                    state_d     = WB_BUSY;
                end
            end
            WB_BUSY: begin
                if (t_ack) begin
                    bus_clear = 1'b1;
                    rd_buf_d  = we_q ? '0 : wb.wb_dat_i;
                    err_buf_d = 1'b0;
                    cpu_data  = rd_buf_d;
                    state_d   = (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
                end else if (t_err || (t_rty && !retry_left) || wd_expire) begin
                    bus_clear = 1'b1;
                    rd_buf_d  = '0;
                    err_buf_d = 1'b1;
                    cpu_err   = 1'b1;
                    state_d   = (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
                end else if (t_rty) begin
                    // Request fields stay latched so the re-issue is identical.
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    retry_cnt_d = retry_cnt_q + RW'(1);
                    stallreq    = 1'b1;
                    state_d     = WB_RETRY_GAP;
                end else if (flush_i) begin
                    bus_clear = 1'b1;
                    rd_buf_d  = '0;
                    state_d   = WB_IDLE;
                end else begin
                    stallreq = 1'b1;
                end
            end
            WB_RETRY_GAP: begin
                if (flush_i) begin
                    bus_clear = 1'b1;
                    state_d   = WB_IDLE;
                end else begin
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    wd_clear = 1'b1;
                    stallreq = 1'b1;
                    state_d  = WB_BUSY;
                end
            end
            WB_WAIT_FOR_STALL: begin
                cpu_data = rd_buf_q;
                cpu_err  = err_buf_q;
                if (stall_i == '0) begin
                    state_d = WB_IDLE;
                end
            end
            default: begin
                bus_clear = 1'b1;
                state_d   = WB_IDLE;
            end
        endcase

        if (bus_clear) begin
            adr_d = '0;
            dat_d = '0;
            we_d  = 1'b0;
            sel_d = '0;
            stb_d = 1'b0;
            cyc_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WB_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
            rd_buf_q    <= '0;
            err_buf_q   <= 1'b0;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            stb_q       <= stb_d;
            cyc_q       <= cyc_d;
            rd_buf_q    <= rd_buf_d;
            err_buf_q   <= err_buf_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign cpu_data_o  = rst ? '0 : cpu_data;
    assign cpu_err_o   = rst ? 1'b0 : cpu_err;
    assign stallreq_o  = rst ? 1'b0 : stallreq;

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_cyc_o = cyc_q;
endmodule
